vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Read side of the 160x120x3 pixel framebuffer that the game FSM writes (x, y, colour, plot).
//  Generates 640x480@60 timing from the 50 MHz clock, fetches one framebuffer word per pixel
//  and upscales 4x4. Expands RGB bits to the 10-bit DAC buses.
//  Emits a one-cycle frame_start at the start of vertical blanking so the game can update off-screen.
// PARAMETERS
//  H_VISIBLE 640  active pixels per line      | H_FRONT 16 | H_SYNC 96 | H_BACK 48 (pixel periods)
//  V_VISIBLE 480  active lines per frame      | V_FRONT 10 | V_SYNC 2  | V_BACK 33 (lines)
//  SCALE_SHIFT 2  log2 upscale; fb_x = h_cnt>>2, fb_y = v_cnt>>2
//  FB_WIDTH 160   framebuffer row pitch in words
// PORTS
//  clock        in   1   50 MHz system clock
//  reset        in   1   asynchronous, active-high
//  mem_addr     out  15  framebuffer read address = fb_y*FB_WIDTH + fb_x (0..19199)
//  mem_rd_en    out  1   read strobe, one clock wide
//  mem_rdata    in   3   {R,G,B}; valid exactly 1 clock after mem_rd_en
//  frame_start  out  1   one-clock pulse on entry to line V_VISIBLE (vertical blank start)
//  VGA_R/G/B    out  10  colour; each bit replicated 10x; 0 while blanked
//  VGA_HS       out  1   horizontal sync, active-low
//  VGA_VS       out  1   vertical sync, active-low
//  VGA_BLANK_N  out  1   1 = active video
//  VGA_SYNC_N   out  1   constant 1
//  VGA_CLK      out  1   25 MHz pixel clock to DAC
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0, pix_en=0, mem_rd_en=0, mem_addr=0, frame_start=0, VGA_R/G/B=0,
//    VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_CLK=0. Reset mid-frame takes effect immediately (async);
//    after release, scan restarts at pixel (0,0); no partial pulse of frame_start.
//  - pix_en toggles every clock (first pix_en=1 on 2nd clock after reset release). Counters advance on pix_en.
//  - h_cnt 0..799 wraps to 0 and increments v_cnt; v_cnt 0..524 wraps to 0. No other wrap.
//  - visible = h_cnt<640 && v_cnt<480. On a pix_en clock with visible: mem_addr = (v_cnt>>2)*160 +
//    (h_cnt>>2) computed as (y<<7)+(y<<5)+x, 15-bit, registered; mem_rd_en=1 for that clock only.
//  - Output stage registers on the next pix_en clock: colour from mem_rdata, HS/VS/BLANK from the
//    same pixel's counters delayed through an identical 2-clock pipe. Net latency counters->pins = 2 clocks.
//  - HS low for h_cnt 656..751; VS low for v_cnt 490..491 (both before delay).
//  - Colour while !visible: 0 regardless of mem_rdata; mem_rd_en stays 0.
//  - VGA_CLK = registered ~pix_en: rising edge mid-way through each output's 2-clock hold.
//  - frame_start: high for exactly one clock when h_cnt wraps 799->0 and new v_cnt==480; 1 per 840000 clocks.
//  - mem_rdata never X-sampled outside the valid cycle.
//  - State: counters only (no FSM beyond pipeline); all arithmetic unsigned, no overflow by construction.
// CONFIGURATION
//  VGA_SCANOUT_TESTPATTERN_EN defined: adds input test_mode (1 bit). When 1, colour = h_cnt[7:5]
//    (8 vertical bars of 32 px per 256 px), mem_rd_en held 0, timing unchanged; switching takes
//    effect at next pixel. When 0, identical to undefined build.
//  Undefined: no test_mode port; colour always from framebuffer.
// TESTING
//  1 Hold reset 5 clks, release -> all outputs at reset values until first pix_en; VGA_SYNC_N=1 always.
//  2 Run 2 lines -> HS period 1600 clks, low for 192 clks starting 2 clks after h_cnt=656; BLANK_N high 1280 clks/line.
//  3 Run 1 frame -> VS period 840000 clks, low 3200 clks; single frame_start per frame, coincident with v_cnt=480,h_cnt=0.
//  4 Model memory; at pixel (h=4..7, v=4..7) mem_addr=161 on 4 consecutive pix_en; return 3'b101 -> R=10'h3FF,G=0,B=10'h3FF 2 clks later.
//  5 At h_cnt=640 with mem_rdata=3'b111 forced -> mem_rd_en=0, R/G/B=0, BLANK_N=0; last pixel (639,479) addr=19199.
//  6 Assert reset at h_cnt=300,v_cnt=200 -> outputs to reset values same cycle; after release first mem_addr=0; (macro build) test_mode=1 -> bar colour 3'b001 at h_cnt 32..63.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 160x120x3 framebuffer.
// Generates 640x480@60 timing from the 50 MHz clock (pixel enable every other clock),
// fetches one framebuffer word per visible pixel, upscales 4x4 and drives the DAC pins.
// Optional build macro: VGA_SCANOUT_TESTPATTERN_EN adds input test_mode, which replaces
// framebuffer colour with eight 32-pixel vertical colour bars.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clock,
  input  logic        reset,
`ifdef VGA_SCANOUT_TESTPATTERN_EN
  input  logic        test_mode,
`endif
  output logic [14:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [2:0]  mem_rdata,
  output logic        frame_start,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK
);

  // Counter landmarks; sync windows are [BEG, END).
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  // Timing state
  logic        pix_en_q, pix_en_d;
  logic        vga_clk_q, vga_clk_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        frame_start_q, frame_start_d;

  // Fetch stage
  logic        visible_s, hs_raw_s, vs_raw_s, fetch_s;
  logic [14:0] fb_addr_s;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_en_q, mem_rd_en_d;

  // Pipe stage 1 (same pixel as the outstanding read) and output stage
  logic        vis_p1_q, vis_p1_d;
  logic        hs_p1_q, hs_p1_d;
  logic        vs_p1_q, vs_p1_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
  logic        tm_p1_q, tm_p1_d;
  logic [2:0]  bar_p1_q, bar_p1_d;
`endif

  // Pixel enable, DAC clock and the raster counters; frame_start marks entry to vertical blank.
  always_comb begin
    pix_en_d      = ~pix_en_q;
    vga_clk_d     = ~pix_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
        if (v_cnt_q == V_VIS_M1) begin
          frame_start_d = 1'b1;
        end else begin
          frame_start_d = 1'b0;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end
  end

  // Decode the current pixel and issue one framebuffer read per visible pixel.
  always_comb begin
    visible_s = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_raw_s  = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_raw_s  = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    // fb_y*160 + fb_x as (y<<7)+(y<<5)+x; max 119*160+159 = 19199 fits in 15 bits.
    fb_addr_s = {1'b0, v_cnt_q[8:2], 7'd0} + {3'b000, v_cnt_q[8:2], 5'd0} + {7'd0, h_cnt_q[9:2]};
`ifdef VGA_SCANOUT_TESTPATTERN_EN
    fetch_s   = pix_en_q & visible_s & ~test_mode;
`else
    fetch_s   = pix_en_q & visible_s;
`endif
    mem_rd_en_d = fetch_s;
    if (fetch_s) begin
      mem_addr_d = fb_addr_s;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // Two-stage pixel pipe: syncs/blank travel alongside the read so colour and timing stay aligned.
  always_comb begin
    vis_p1_d  = vis_p1_q;
    hs_p1_d   = hs_p1_q;
    vs_p1_d   = vs_p1_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
    tm_p1_d   = tm_p1_q;
    bar_p1_d  = bar_p1_q;
`endif
    if (pix_en_q) begin
      vis_p1_d  = visible_s;
      hs_p1_d   = hs_raw_s;
      vs_p1_d   = vs_raw_s;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      tm_p1_d   = test_mode;
      bar_p1_d  = h_cnt_q[7:5];
`endif
      hs_d      = hs_p1_q;
      vs_d      = vs_p1_q;
      blank_n_d = vis_p1_q;
      // mem_rdata is only looked at when a read was issued for this pixel.
      if (!vis_p1_q) begin
        rgb_d = 3'b000;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      end else if (tm_p1_q) begin
        rgb_d = bar_p1_q;
`endif
      end else begin
        rgb_d = mem_rdata;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  // State registers; reset parks the raster at pixel (0,0) with all pins idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      frame_start_q <= 1'b0;
      mem_addr_q    <= 15'd0;
      mem_rd_en_q   <= 1'b0;
      vis_p1_q      <= 1'b0;
      hs_p1_q       <= 1'b1;
      vs_p1_q       <= 1'b1;
      rgb_q         <= 3'b000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      tm_p1_q       <= 1'b0;
      bar_p1_q      <= 3'b000;
`endif
    end else begin
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      vis_p1_q      <= vis_p1_d;
      hs_p1_q       <= hs_p1_d;
      vs_p1_q       <= vs_p1_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      tm_p1_q       <= tm_p1_d;
      bar_p1_q      <= bar_p1_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = {10{rgb_q[2]}};
  assign VGA_G       = {10{rgb_q[1]}};
  assign VGA_B       = {10{rgb_q[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_CLK     = vga_clk_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full horizontal timing, vertical timing shortened to 26 lines so a
// whole frame fits in a short run. A per-cycle model derives every pin from the raster position
// implied by the clock count since reset release; directed literal checks pin key points.
module tb_vga_scanout;

  localparam int H_TOT  = 800;
  localparam int V_VIS  = 20;
  localparam int V_TOT  = 26;
  localparam int VS_BEG = 22;
  localparam int VS_END = 24;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        test_mode = 1'b0;
  logic [14:0] mem_addr;
  logic        mem_rd_en;
  logic [2:0]  mem_rdata = 3'b111;
  logic        frame_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;
  int ncyc  = 0;
  bit tm_hist[int];

  vga_scanout #(
    .V_VISIBLE(V_VIS), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .clock(clock), .reset(reset),
`ifdef VGA_SCANOUT_TESTPATTERN_EN
    .test_mode(test_mode),
`endif
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .frame_start(frame_start), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  always #10 clock = ~clock;

  // Framebuffer contents: low bits xor next bits of the address (fb(161) = 3'b101).
  function automatic logic [2:0] fb(input int a);
    logic [14:0] w;
    w = 15'(a);
    return w[2:0] ^ w[5:3];
  endfunction

  function automatic int pix_addr(input int h, input int v);
    return (v / 4) * 160 + (h / 4);
  endfunction

  function automatic bit tm_of(input int p);
    if (tm_hist.exists(p)) return tm_hist[p];
    return 1'b0;
  endfunction

  task automatic finish_up();
    if (!done) begin
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t n=%0d: got %0h expected %0h", name, $time, ncyc, got, exp);
      if (bad >= 100) finish_up();
    end
  endtask

  // Clock edges since reset release: after edge n the raster is at pixel floor(n/2).
  always @(posedge clock or posedge reset) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  // Synchronous memory: data one clock after a read strobe, junk otherwise.
  always @(posedge clock) begin
    mem_rdata <= mem_rd_en ? fb(int'(mem_addr)) : 3'b111;
  end

  // Remember which pixels were sampled with test_mode set (pixel p sampled at edge 2p+2).
  always @(posedge clock) begin
    if (!reset && (ncyc % 2 == 1)) tm_hist[(ncyc + 1) / 2 - 1] = test_mode;
  end

  logic [36:0] pins_s;
  assign pins_s = {mem_rd_en, frame_start, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, VGA_SYNC_N,
                   VGA_R, VGA_G, VGA_B};

  // Per-cycle comparison of all pins against the raster-position model.
  always @(negedge clock) begin : cmp
    int n, p, q, h, v;
    logic rd_e, fs_e, hs_e, vs_e, bl_e, clk_e;
    logic [2:0] c_e;
    if (reset) begin
      check("reset_pins", pins_s, {7'b0011001, 30'd0});
      check("reset_addr", mem_addr, 15'd0);
    end else begin
      n = ncyc;
      rd_e = 1'b0;
      if (n >= 2 && n % 2 == 0) begin
        p = n / 2 - 1;
        h = p % H_TOT;
        v = (p / H_TOT) % V_TOT;
        if (h < 640 && v < V_VIS && !tm_of(p)) begin
          rd_e = 1'b1;
          check("fetch_addr", mem_addr, pix_addr(h, v));
        end
      end
      fs_e  = (n >= 2 && n % 2 == 0 && (n / 2) % (H_TOT * V_TOT) == V_VIS * H_TOT);
      clk_e = (n % 2 == 1);
      if (n < 4) begin
        hs_e = 1'b1; vs_e = 1'b1; bl_e = 1'b0; c_e = 3'b000;
      end else begin
        q = n / 2 - 2;
        h = q % H_TOT;
        v = (q / H_TOT) % V_TOT;
        bl_e = (h < 640 && v < V_VIS);
        hs_e = !(h >= 656 && h < 752);
        vs_e = !(v >= VS_BEG && v < VS_END);
        if (!bl_e) c_e = 3'b000;
        else if (tm_of(q)) c_e = 3'((h / 32) % 8);
        else c_e = fb(pix_addr(h, v));
      end
      check("pins", pins_s, {rd_e, fs_e, hs_e, vs_e, bl_e, clk_e, 1'b1,
                             {10{c_e[2]}}, {10{c_e[1]}}, {10{c_e[0]}}});
    end
  end

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (ncyc < target && guard < 60000) begin
      @(negedge clock);
      guard++;
    end
    check("wait_cyc", ncyc, target);
  endtask

  initial begin
    // Reset held for 5 clocks, released mid low phase.
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst_hs", VGA_HS, 1'b1);
    check("rst_sync_n", VGA_SYNC_N, 1'b1);
    #5 reset = 1'b0;

    wait_cyc(1);
    check("first_clk", VGA_CLK, 1'b1);
    check("first_blank", VGA_BLANK_N, 1'b0);
    check("first_rd", mem_rd_en, 1'b0);

    // End of the first visible line.
    wait_cyc(1280);
    check("last_px_rd", mem_rd_en, 1'b1);
    check("last_px_addr", mem_addr, 15'd159);
    wait_cyc(1282);
    check("h640_rd", mem_rd_en, 1'b0);
    wait_cyc(1283);
    check("blank_last_vis", VGA_BLANK_N, 1'b1);
    wait_cyc(1284);
    check("h640_blank", VGA_BLANK_N, 1'b0);
    check("h640_rgb", {VGA_R, VGA_G, VGA_B}, 30'd0);

    // HS: low 192 clocks starting 2 clocks after h_cnt reaches 656; period 1600.
    wait_cyc(1315); check("hs_before", VGA_HS, 1'b1);
    wait_cyc(1316); check("hs_fall", VGA_HS, 1'b0);
    wait_cyc(1507); check("hs_hold", VGA_HS, 1'b0);
    wait_cyc(1508); check("hs_rise", VGA_HS, 1'b1);
    wait_cyc(2915); check("hs_before_l1", VGA_HS, 1'b1);
    wait_cyc(2916); check("hs_fall_l1", VGA_HS, 1'b0);

    // Pixel block (4..7, 4..7) maps to word 161 holding 3'b101.
    wait_cyc(6410); check("addr161_a", mem_addr, 15'd161);
    wait_cyc(6412); check("addr161_b", mem_addr, 15'd161);
    check("r_101", VGA_R, 10'h3FF);
    check("g_101", VGA_G, 10'h000);
    check("b_101", VGA_B, 10'h3FF);
    wait_cyc(6414); check("addr161_c", mem_addr, 15'd161);
    wait_cyc(6416); check("addr161_d", mem_addr, 15'd161);
    wait_cyc(6418); check("addr162", mem_addr, 15'd162);

    // Last visible pixel of the shortened frame: (639, 19) -> 4*160+159.
    wait_cyc(31680); check("last_addr", mem_addr, 15'd799);

    // frame_start: exactly one clock on entry to line V_VIS.
    wait_cyc(31999); check("fs_before", frame_start, 1'b0);
    wait_cyc(32000); check("fs_pulse", frame_start, 1'b1);
    wait_cyc(32001); check("fs_after", frame_start, 1'b0);

    // VS low for lines 22..23 (3200 clocks).
    wait_cyc(35203); check("vs_before", VGA_VS, 1'b1);
    wait_cyc(35204); check("vs_fall", VGA_VS, 1'b0);
    wait_cyc(38403); check("vs_hold", VGA_VS, 1'b0);
    wait_cyc(38404); check("vs_rise", VGA_VS, 1'b1);

    // Frame wrap back to word 0.
    wait_cyc(41602);
    check("wrap_rd", mem_rd_en, 1'b1);
    check("wrap_addr", mem_addr, 15'd0);

    // Asynchronous reset mid-line at h=300, v=2.
    wait_cyc(45401);
    check("pre_rst_blank", VGA_BLANK_N, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("arst_clk", VGA_CLK, 1'b0);
    check("arst_blank", VGA_BLANK_N, 1'b0);
    check("arst_hs_vs", {VGA_HS, VGA_VS}, 2'b11);
    check("arst_rgb", {VGA_R, VGA_G, VGA_B}, 30'd0);
    check("arst_rd", mem_rd_en, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #5 reset = 1'b0;
    wait_cyc(2);
    check("restart_rd", mem_rd_en, 1'b1);
    check("restart_addr", mem_addr, 15'd0);
    check("restart_fs", frame_start, 1'b0);

`ifdef VGA_SCANOUT_TESTPATTERN_EN
    test_mode = 1'b1;
    wait_cyc(84);
    check("bar1_rgb", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h000, 10'h3FF});
    check("bar_rd_off", mem_rd_en, 1'b0);
    wait_cyc(200);
    test_mode = 1'b0;
`endif
    wait_cyc(400);
    finish_up();
  end

endmodule
